shift_operand_skid: RTL
=======================

// Module: shift_operand_skid
// PURPOSE
//   Two-entry skid buffer between decode and the execute-stage barrel shifter.
//   Carries {In, Cnt, Op, BTR, dest reg} from decode and presents them registered
//   to the shifter with valid/ready flow control.
//   Absorbs one cycle of downstream backpressure without dropping an operand.
//   Supports a pipeline flush on branch mispredict.
// PARAMETERS
//   N  16  operand/data width (shifter In/Out width)
//   C  4   shift count width
//   O  2   shift op width (00 rotl, 01 shl, 10 rotr, 11 srl)
//   R  3   destination register index width
// PORTS
//   clk        in   1  system clock, all state updates on posedge
//   rst        in   1  asynchronous, active-high reset
//   flush      in   1  synchronous flush, drops every held entry
//   in_valid   in   1  decode presents a valid operand set
//   in_ready   out  1  buffer can accept (registered: high iff skid entry empty)
//   in_data    in   N  value to shift
//   in_cnt     in   C  shift amount
//   in_op      in   O  shift op
//   in_btr     in   1  bit-reverse request (overrides op/cnt)
//   in_rd      in   R  destination register
//   out_valid  out  1  operand set valid toward shifter
//   out_ready  in   1  shifter/EX-MEM stage accepts this cycle
//   out_data   out  N  registered operand to shifter In
//   out_cnt    out  C  registered count to shifter Cnt
//   out_op     out  O  registered op to shifter Op
//   out_btr    out  1  registered BTR to shifter
//   out_rd     out  R  registered destination register
//   stall_cnt  out  16 backpressure counter (only with SHIFT_SKID_STATS_EN)
// BEHAVIOUR
//   Reset: all outputs 0 except in_ready=1; state EMPTY; both entries invalid.
//   Handshake: push = in_valid & in_ready; pop = out_valid & out_ready.
//   Latency: pushed item appears on out_* the cycle after push (1 cycle).
//   States (main = output reg, skid = overflow reg):
//     EMPTY: push -> ONE (load main).
//     ONE:   push & !pop -> FULL (load skid); push & pop -> ONE (reload main);
//            !push & pop -> EMPTY; else hold.
//     FULL:  in_ready=0; pop -> ONE (skid moves to main, skid cleared); else hold.
//   Ordering strictly FIFO; no item duplicated or dropped except by flush/reset.
//   Stability: while out_valid & !out_ready, all out_* hold their values.
//   in_valid asserted while in_ready=0: ignored, no state change.
//   Normalisation on load: if in_btr=1, out_cnt and out_op are forced to 0
//     regardless of in_cnt/in_op; in_data and in_rd pass unchanged.
//   Flush: next cycle EMPTY, out_valid=0, in_ready=1; out_* data regs are
//     zeroed. Flush wins over a simultaneous push or pop.
//     The push is dropped; a pop in the same cycle still counts downstream.
//   Reset mid-operation: immediate (async) return to reset values.
//   Widths: payload widths fixed by parameters; no arithmetic on payload.
// CONFIGURATION
//   SHIFT_SKID_STATS_EN defined:
//     stall_cnt port exists.
//     +1 each cycle out_valid & !out_ready; saturates at 16'hFFFF.
//     Cleared by rst only; not cleared by flush.
//   SHIFT_SKID_STATS_EN undefined:
//     stall_cnt port and counter logic absent; all other behaviour identical.
// TESTING
//   1 rst pulse -> out_valid=0, in_ready=1, out_*=0, state EMPTY.
//   2 push {data=16'hA0A0, cnt=4, op=01, btr=0, rd=3}, out_ready=1
//     -> next cycle out_valid=1, out_data=A0A0, out_cnt=4; popped next edge.
//   3 out_ready=0; push 16'h1111 then 16'h2222
//     -> in_ready=0 after second push; out_data holds 1111.
//     -> out_ready=1 gives 1111 then 2222, in order.
//   4 push with btr=1, cnt=7, op=10 -> out_btr=1, out_cnt=0, out_op=00.
//   5 FULL state; assert flush together with in_valid
//     -> next cycle out_valid=0, in_ready=1, pushed item never appears.
//   6 (STATS_EN) hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=10;
//     flush -> stall_cnt stays 10; rst -> 0.
//   Random: random in_valid/out_ready/flush vs a queue scoreboard, 5000 cycles.

Source files
------------

// File: rtl/shift_operand_skid.sv
// Two-entry skid buffer feeding operands from decode into the execute-stage barrel shifter.
// Optional backpressure statistics counter enabled by defining SHIFT_SKID_STATS_EN.
module shift_operand_skid #(
  parameter int unsigned N = 16,
  parameter int unsigned C = 4,
  parameter int unsigned O = 2,
  parameter int unsigned R = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [C-1:0] in_cnt,
  input  logic [O-1:0] in_op,
  input  logic         in_btr,
  input  logic [R-1:0] in_rd,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [C-1:0] out_cnt,
  output logic [O-1:0] out_op,
  output logic         out_btr,
  output logic [R-1:0] out_rd
`ifdef SHIFT_SKID_STATS_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);

  localparam int unsigned P = N + C + O + 1 + R;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e         state_q, state_d;
  logic [P-1:0]   main_q, main_d;
  logic [P-1:0]   skid_q, skid_d;
  logic [P-1:0]   in_norm;
  logic           push, pop;

  // Bit-reverse overrides the op and count, so they are stored as zero.
  assign in_norm = in_btr ? {in_data, {C{1'b0}}, {O{1'b0}}, 1'b1, in_rd}
                          : {in_data, in_cnt, in_op, 1'b0, in_rd};

  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign {out_data, out_cnt, out_op, out_btr, out_rd} = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            main_d  = in_norm;
            state_d = StOne;
          end
        end
        StOne: begin
          if (push && !pop) begin
            skid_d  = in_norm;
            state_d = StFull;
          end else if (push && pop) begin
            main_d = in_norm;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef SHIFT_SKID_STATS_EN
  logic [15:0] stall_q, stall_d;

  // Saturating; flush deliberately leaves the count alone.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
